wbc_uart_rxfifo: RTL and testbench

Receive-side buffering stage that sits directly downstream of the serial receiver. It captures each received character together with its parity and break status into a DEPTH-entry FIFO. It presents the characters to the CPU as a Wishbone register set with threshold interrupts that cooperate with wbc_vic. It also drives hardware flow control, with hysteresis, back toward the remote transmitter.

---
 rtl/wbc_uart_pkg.sv | 23 ++
 rtl/wbc_sync_fifo.sv | 52 +++++
 rtl/wbc_uart_rxfifo.sv | 125 ++++++++++++
 tb/tb_wbc_uart_rxfifo.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wbc_uart_pkg.sv
// rtl/wbc_uart_pkg.sv - shared register map and CSR bit positions for the UART RX path
package wbc_uart_pkg;

    typedef enum logic [1:0] {
        REG_RCSR = 2'd0,
        REG_RBUF = 2'd1,
        REG_RLVL = 2'd2,
        REG_RSVD = 2'd3
    } reg_sel_e;

    localparam int CSR_ERR   = 15;
    localparam int CSR_OVF   = 12;
    localparam int CSR_PERR  = 11;
    localparam int CSR_DONE  = 7;
    localparam int CSR_IE    = 6;
    localparam int CSR_FLUSH = 0;

    // FIFO entry layout: {perr, brk, data[7:0]}
    localparam int ENT_PERR  = 9;
    localparam int ENT_BRK   = 8;
    localparam int ENT_WIDTH = 10;

endpackage

// File: rtl/wbc_sync_fifo.sv
// rtl/wbc_sync_fifo.sv - single-clock FIFO with push/pop/flush, full/empty and occupancy count
module wbc_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push then.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/wbc_uart_rxfifo.sv
// rtl/wbc_uart_rxfifo.sv - UART receive FIFO with Wishbone registers, threshold IRQ and RTS hysteresis
module wbc_uart_rxfifo
    import wbc_uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int RTS_HI = 12,
    parameter int RTS_LO = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [2:0]  wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    input  logic [7:0]  rx_dat_i,
    input  logic        rx_stb_i,
    input  logic        rx_perr_i,
    input  logic        rx_brk_i,
    output logic        rts_o,
    output logic        irq_o,
    input  logic        iack_i
);
    reg_sel_e             sel;
    logic                 acc, rd_rbuf, wr_rcsr, wr_rlvl, flush;
    logic                 drop, stored;
    logic [ENT_WIDTH-1:0] head;
    logic                 full, empty;
    logic [AW:0]          count;
    logic [15:0]          cnt16, thr_e;
    logic [15:0]          rdata;
    logic                 ie, ovf, perr;
    logic [3:0]           thr;
    logic                 cond, cond_d, pending;
    logic                 unused_ok;

    assign sel     = reg_sel_e'(wb_adr_i[2:1]);
    assign acc     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign rd_rbuf = acc & ~wb_we_i & (sel == REG_RBUF);
    assign wr_rcsr = acc &  wb_we_i & (sel == REG_RCSR);
    assign wr_rlvl = acc &  wb_we_i & (sel == REG_RLVL);
    assign flush   = wr_rcsr & wb_dat_i[CSR_FLUSH];

    // A flush swallows a simultaneous character silently; only a genuine full-drop is an overrun.
    assign drop    = rx_stb_i & ~flush & full & ~rd_rbuf;
    assign stored  = rx_stb_i & ~flush & ~drop;

    wbc_sync_fifo #(.DEPTH(DEPTH), .WIDTH(ENT_WIDTH)) u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (rx_stb_i),
        .wdata ({rx_perr_i, rx_brk_i, rx_dat_i}),
        .pop   (rd_rbuf),
        .flush (flush),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign cnt16 = 16'(count);
    assign thr_e = (thr == 4'd0) ? 16'd1 : 16'(thr);
    assign cond  = ie & (cnt16 >= thr_e);

    always_comb begin
        rdata = '0;
        case (sel)
            REG_RCSR: begin
                rdata[CSR_ERR]  = ovf | perr;
                rdata[CSR_OVF]  = ovf;
                rdata[CSR_PERR] = perr;
                rdata[CSR_DONE] = ~empty;
                rdata[CSR_IE]   = ie;
            end
            REG_RBUF: begin
                if (!empty) rdata = {head[ENT_PERR], head[ENT_BRK], 6'b0, head[7:0]};
            end
            REG_RLVL: begin
                rdata        = cnt16;
                rdata[11:8]  = thr;
            end
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            ie       <= 1'b0;
            thr      <= '0;
            ovf      <= 1'b0;
            perr     <= 1'b0;
            rts_o    <= 1'b1;
            cond_d   <= 1'b0;
            pending  <= 1'b0;
            irq_o    <= 1'b0;
        end else begin
            wb_ack_o <= acc;
            if (acc)     wb_dat_o <= rdata;
            if (wr_rcsr) ie <= wb_dat_i[CSR_IE];
            if (wr_rlvl) thr <= wb_dat_i[11:8];

            if (drop)         ovf <= 1'b1;
            else if (wr_rcsr) ovf <= 1'b0;
            if (stored && rx_perr_i) perr <= 1'b1;
            else if (wr_rcsr)        perr <= 1'b0;

            if (cnt16 >= 16'(RTS_HI))      rts_o <= 1'b0;
            else if (cnt16 <= 16'(RTS_LO)) rts_o <= 1'b1;

            // Edge-triggered request: an acknowledged level stays quiet until it re-arms.
            cond_d <= cond;
            if (cond && !cond_d)      pending <= 1'b1;
            else if (iack_i || !cond) pending <= 1'b0;
            irq_o <= pending;
        end
    end

    assign unused_ok = ^{wb_adr_i[0], wb_dat_i[15:12], wb_dat_i[7], wb_dat_i[5:1]};

endmodule

// File: tb/tb_wbc_uart_rxfifo.sv
// tb/tb_wbc_uart_rxfifo.sv - self-checking bench for wbc_uart_rxfifo
module tb_wbc_uart_rxfifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  adr = '0;
    logic [15:0] dat_w = '0;
    logic [15:0] dat_r;
    logic        cyc = 1'b0, we = 1'b0, stb = 1'b0, ack;
    logic [7:0]  rx_dat = '0;
    logic        rx_stb = 1'b0, rx_perr = 1'b0, rx_brk = 1'b0;
    logic        rts, irq;
    logic        iack = 1'b0;

    always #5 clk = ~clk;

    wbc_uart_rxfifo dut (
        .wb_clk_i (clk),    .wb_rst_i (rst),
        .wb_adr_i (adr),    .wb_dat_i (dat_w),  .wb_dat_o (dat_r),
        .wb_cyc_i (cyc),    .wb_we_i  (we),     .wb_stb_i (stb),  .wb_ack_o (ack),
        .rx_dat_i (rx_dat), .rx_stb_i (rx_stb), .rx_perr_i(rx_perr), .rx_brk_i(rx_brk),
        .rts_o    (rts),    .irq_o    (irq),    .iack_i   (iack)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    // Optional push in the same cycle as an optional bus access.
    task automatic cycle_op(input logic do_bus, input logic w, input logic [2:0] a,
                            input logic [15:0] d, input logic do_push,
                            input logic [7:0] c, input logic p, input logic b,
                            output logic [15:0] rd);
        @(negedge clk);
        cyc = do_bus; stb = do_bus; we = w; adr = a; dat_w = d;
        rx_stb = do_push; rx_dat = c; rx_perr = p; rx_brk = b;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; rx_stb = 1'b0; rx_perr = 1'b0; rx_brk = 1'b0;
        rd = dat_r;
        if (do_bus) begin
            check("ack", int'(ack), 1);
            step();
        end
    endtask

    task automatic push(input logic [7:0] c, input logic p, input logic b);
        logic [15:0] rd;
        cycle_op(1'b0, 1'b0, 3'd0, 16'd0, 1'b1, c, p, b, rd);
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [15:0] rd);
        cycle_op(1'b1, 1'b0, a, 16'd0, 1'b0, 8'd0, 1'b0, 1'b0, rd);
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [15:0] d);
        logic [15:0] rd;
        cycle_op(1'b1, 1'b1, a, d, 1'b0, 8'd0, 1'b0, 1'b0, rd);
    endtask

    typedef enum int {OP_PUSH, OP_RD, OP_WR} op_e;
    typedef struct {
        op_e         op;
        logic [2:0]  a;
        logic [15:0] d;
        logic        p;
        logic        b;
        logic [15:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [9:0]  q[$];
    logic [15:0] rd;
    logic [9:0]  e;
    bit          ovf_m, perr_m, rts_m;

    function automatic logic [15:0] rcsr_model();
        logic [15:0] v;
        v = '0;
        v[15] = ovf_m | perr_m;
        v[12] = ovf_m;
        v[11] = perr_m;
        v[7]  = (q.size() != 0);
        return v;
    endfunction

    initial begin
        vecs = '{
            '{OP_RD,   3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000},
            '{OP_RD,   3'd2, 16'h0000, 1'b0, 1'b0, 16'h0000},
            '{OP_RD,   3'd4, 16'h0000, 1'b0, 1'b0, 16'h0000},
            '{OP_PUSH, 3'd0, 16'h0041, 1'b0, 1'b0, 16'h0000},
            '{OP_PUSH, 3'd0, 16'h0042, 1'b1, 1'b0, 16'h0000},
            '{OP_RD,   3'd2, 16'h0000, 1'b0, 1'b0, 16'h0041},
            '{OP_RD,   3'd2, 16'h0000, 1'b0, 1'b0, 16'h8042},
            '{OP_RD,   3'd0, 16'h0000, 1'b0, 1'b0, 16'h8800},
            '{OP_WR,   3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000},
            '{OP_RD,   3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000},
            '{OP_RD,   3'd2, 16'h0000, 1'b0, 1'b0, 16'h0000},
            '{OP_WR,   3'd4, 16'h0300, 1'b0, 1'b0, 16'h0000},
            '{OP_RD,   3'd4, 16'h0000, 1'b0, 1'b0, 16'h0300},
            '{OP_PUSH, 3'd0, 16'h0055, 1'b0, 1'b1, 16'h0000},
            '{OP_RD,   3'd4, 16'h0000, 1'b0, 1'b0, 16'h0301},
            '{OP_RD,   3'd0, 16'h0000, 1'b0, 1'b0, 16'h0080},
            '{OP_RD,   3'd2, 16'h0000, 1'b0, 1'b0, 16'h4055},
            '{OP_WR,   3'd6, 16'hffff, 1'b0, 1'b0, 16'h0000},
            '{OP_RD,   3'd6, 16'h0000, 1'b0, 1'b0, 16'h0000},
            '{OP_RD,   3'd4, 16'h0000, 1'b0, 1'b0, 16'h0300},
            '{OP_RD,   3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000}
        };

        do_reset();
        step();
        check("reset rts", int'(rts), 1);
        check("reset irq", int'(irq), 0);
        check("reset ack", int'(ack), 0);
        check("reset dat", int'(dat_r), 0);

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_PUSH: push(vecs[i].d[7:0], vecs[i].p, vecs[i].b);
                OP_WR:   bus_wr(vecs[i].a, vecs[i].d);
                default: begin
                    bus_rd(vecs[i].a, rd);
                    check($sformatf("vec%0d", i), int'(rd), int'(vecs[i].exp));
                end
            endcase
        end

        // Overflow and RTS hysteresis
        do_reset();
        for (int i = 0; i < 17; i++) begin
            push(8'h10 + 8'(i), 1'b0, 1'b0);
            step();
            if (i == 10) check("rts at 11", int'(rts), 1);
            if (i == 11) check("rts at 12", int'(rts), 0);
        end
        bus_rd(3'd4, rd); check("ovf count", int'(rd), 16'h0010);
        bus_rd(3'd0, rd); check("ovf rcsr", int'(rd), 16'h9080);
        for (int k = 0; k < 16; k++) begin
            bus_rd(3'd2, rd);
            check($sformatf("ovf data%0d", k), int'(rd), 16'h0010 + k);
            step();
            if (15 - k == 5) check("rts at 5", int'(rts), 0);
            if (15 - k == 4) check("rts at 4", int'(rts), 1);
        end
        bus_rd(3'd2, rd); check("byte17 lost", int'(rd), 0);

        // Threshold interrupt
        do_reset();
        bus_wr(3'd4, 16'h0300);
        bus_wr(3'd0, 16'h0040);
        push(8'h01, 1'b0, 1'b0);
        push(8'h02, 1'b0, 1'b0);
        repeat (3) step();
        check("irq below thr", int'(irq), 0);
        push(8'h03, 1'b0, 1'b0);
        step();
        check("irq latency1", int'(irq), 0);
        step();
        check("irq at thr", int'(irq), 1);
        @(negedge clk); iack = 1'b1;
        @(posedge clk); #1; iack = 1'b0;
        step();
        check("irq after iack", int'(irq), 0);
        push(8'h04, 1'b0, 1'b0);
        repeat (3) step();
        check("irq no rereq", int'(irq), 0);
        bus_rd(3'd2, rd);
        bus_rd(3'd2, rd);
        repeat (2) step();
        check("irq at 2", int'(irq), 0);
        push(8'h05, 1'b0, 1'b0);
        step(); step();
        check("irq rereq", int'(irq), 1);

        // Push and pop together while full
        do_reset();
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i), 1'b0, 1'b0);
        cycle_op(1'b1, 1'b0, 3'd2, 16'd0, 1'b1, 8'hAA, 1'b0, 1'b0, rd);
        check("full pp head", int'(rd), 16'h0020);
        bus_rd(3'd4, rd); check("full pp count", int'(rd), 16'h0010);
        bus_rd(3'd0, rd); check("full pp rcsr", int'(rd), 16'h0080);
        for (int k = 1; k < 16; k++) begin
            bus_rd(3'd2, rd);
            check($sformatf("full pp data%0d", k), int'(rd), 16'h0020 + k);
        end
        bus_rd(3'd2, rd); check("full pp last", int'(rd), 16'h00AA);

        // Flush coinciding with a push
        do_reset();
        for (int i = 0; i < 5; i++) push(8'h60 + 8'(i), 1'b0, 1'b0);
        cycle_op(1'b1, 1'b1, 3'd0, 16'h0001, 1'b1, 8'h77, 1'b1, 1'b0, rd);
        bus_rd(3'd4, rd); check("flush count", int'(rd), 0);
        bus_rd(3'd0, rd); check("flush rcsr", int'(rd), 0);
        bus_rd(3'd2, rd); check("flush rbuf", int'(rd), 0);

        // Reset during an access
        do_reset();
        push(8'h33, 1'b0, 1'b0);
        @(negedge clk); cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 3'd2; rst = 1'b1;
        @(posedge clk); #1; cyc = 1'b0; stb = 1'b0;
        check("rst mid ack", int'(ack), 0);
        @(negedge clk); rst = 1'b0;
        bus_rd(3'd4, rd); check("rst mid count", int'(rd), 0);
        bus_rd(3'd2, rd); check("rst mid rbuf", int'(rd), 0);

        // Randomized traffic against a queue model
        do_reset();
        q.delete(); ovf_m = 0; perr_m = 0; rts_m = 1;
        for (int it = 0; it < 400; it++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 50) begin
                logic [7:0] c;
                logic p, b;
                c = 8'($urandom);
                p = ($urandom_range(0, 7) == 0);
                b = ($urandom_range(0, 7) == 0);
                push(c, p, b);
                if (q.size() == 16) ovf_m = 1;
                else begin
                    q.push_back({p, b, c});
                    if (p) perr_m = 1;
                end
            end else if (r < 80) begin
                logic [15:0] exp;
                exp = '0;
                if (q.size() != 0) begin
                    e = q.pop_front();
                    exp = {e[9], e[8], 6'b0, e[7:0]};
                end
                bus_rd(3'd2, rd);
                check($sformatf("rnd rbuf%0d", it), int'(rd), int'(exp));
            end else if (r < 88) begin
                bus_rd(3'd4, rd);
                check($sformatf("rnd rlvl%0d", it), int'(rd), q.size());
            end else if (r < 95) begin
                bus_rd(3'd0, rd);
                check($sformatf("rnd rcsr%0d", it), int'(rd), int'(rcsr_model()));
            end else begin
                logic f;
                f = ($urandom_range(0, 1) == 1);
                bus_wr(3'd0, {15'd0, f});
                ovf_m = 0; perr_m = 0;
                if (f) q.delete();
            end
            step();
            if (q.size() >= 12)     rts_m = 0;
            else if (q.size() <= 4) rts_m = 1;
            check($sformatf("rnd rts%0d", it), int'(rts), int'(rts_m));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
